// File: rtl/id_ex_hazard_reg_if.sv
// ID/EX stage bus: decoded operands and control entering EX, hazard/stall
// feedback to the front end, and perf-debug visibility.
interface id_ex_hazard_reg_if #(
  parameter int XLEN  = 32,
  parameter int CTRLW = 8,
  parameter int CNTW  = 16
);
  logic             ID_valid;
  logic [4:0]       ID_rs1, ID_rs2, ID_rd;
  logic             ID_uses_rs1, ID_uses_rs2;
  logic [XLEN-1:0]  ID_rs1_data, ID_rs2_data, ID_imm;
  logic [CTRLW-1:0] ID_ctrl;
  logic             ID_regwrite, ID_memread;
  logic             flush_i, mem_stall_i;
  logic             stall_o;
  logic             EX_valid;
  logic [4:0]       EX_rs1, EX_rs2, EX_rd;
  logic [XLEN-1:0]  EX_rs1_data, EX_rs2_data, EX_imm;
  logic [CTRLW-1:0] EX_ctrl;
  logic             EX_regwrite, EX_memread;
  logic [1:0]       state_o;
  logic [CNTW-1:0]  bubble_cnt, flush_cnt;

  modport master (
    output ID_valid, ID_rs1, ID_rs2, ID_rd, ID_uses_rs1, ID_uses_rs2,
           ID_rs1_data, ID_rs2_data, ID_imm, ID_ctrl, ID_regwrite, ID_memread,
           flush_i, mem_stall_i,
    input  stall_o, EX_valid, EX_rs1, EX_rs2, EX_rd, EX_rs1_data, EX_rs2_data,
           EX_imm, EX_ctrl, EX_regwrite, EX_memread, state_o, bubble_cnt, flush_cnt
  );

  modport slave (
    input  ID_valid, ID_rs1, ID_rs2, ID_rd, ID_uses_rs1, ID_uses_rs2,
           ID_rs1_data, ID_rs2_data, ID_imm, ID_ctrl, ID_regwrite, ID_memread,
           flush_i, mem_stall_i,
    output stall_o, EX_valid, EX_rs1, EX_rs2, EX_rd, EX_rs1_data, EX_rs2_data,
           EX_imm, EX_ctrl, EX_regwrite, EX_memread, state_o, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use detection, bubble insertion, flush
// and saturating perf counters. stall_o is combinational back to PC / IF/ID.
module id_ex_hazard_reg #(
  parameter int XLEN  = 32,
  parameter int CTRLW = 8,
  parameter int CNTW  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  id_ex_hazard_reg_if.slave  bus
);
  typedef struct packed {
    logic             valid;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [CTRLW-1:0] ctrl;
    logic             regwrite;
    logic             memread;
  } stage_t;

  typedef enum logic [1:0] {S_RUN, S_BUBBLE, S_FROZEN, S_FLUSHED} state_t;

  stage_t          id_s, ex_q;
  state_t          state_q;
  logic [CNTW-1:0] bcnt_q, fcnt_q;
  logic            hit1, hit2, load_use;

  assign id_s = '{valid:    bus.ID_valid,
                  rs1:      bus.ID_rs1,
                  rs2:      bus.ID_rs2,
                  rd:       bus.ID_rd,
                  rs1_data: bus.ID_rs1_data,
                  rs2_data: bus.ID_rs2_data,
                  imm:      bus.ID_imm,
                  ctrl:     bus.ID_ctrl,
                  regwrite: bus.ID_regwrite,
                  memread:  bus.ID_memread};

  // Only operands the instruction actually reads can create a dependency.
  assign hit1     = bus.ID_uses_rs1 && (bus.ID_rs1 == ex_q.rd);
  assign hit2     = bus.ID_uses_rs2 && (bus.ID_rs2 == ex_q.rd);
  assign load_use = bus.ID_valid && ex_q.valid && ex_q.memread &&
                    (ex_q.rd != 5'd0) && (hit1 || hit2);

  assign bus.stall_o = bus.mem_stall_i | (load_use & ~bus.flush_i);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_q    <= '0;
      state_q <= S_RUN;
      bcnt_q  <= '0;
      fcnt_q  <= '0;
    end else if (bus.mem_stall_i) begin
      state_q <= S_FROZEN;
    end else if (bus.flush_i) begin
      ex_q    <= '0;
      state_q <= S_FLUSHED;
      if (~&fcnt_q) fcnt_q <= fcnt_q + CNTW'(1);
    end else if (load_use) begin
      ex_q    <= '0;
      state_q <= S_BUBBLE;
      if (~&bcnt_q) bcnt_q <= bcnt_q + CNTW'(1);
    end else begin
      // An invalid ID slot is loaded as a fully zeroed bubble.
      ex_q    <= bus.ID_valid ? id_s : '0;
      state_q <= S_RUN;
    end
  end

  assign bus.EX_valid    = ex_q.valid;
  assign bus.EX_rs1      = ex_q.rs1;
  assign bus.EX_rs2      = ex_q.rs2;
  assign bus.EX_rd       = ex_q.rd;
  assign bus.EX_rs1_data = ex_q.rs1_data;
  assign bus.EX_rs2_data = ex_q.rs2_data;
  assign bus.EX_imm      = ex_q.imm;
  assign bus.EX_ctrl     = ex_q.ctrl;
  assign bus.EX_regwrite = ex_q.regwrite;
  assign bus.EX_memread  = ex_q.memread;
  assign bus.state_o     = state_q;
  assign bus.bubble_cnt  = bcnt_q;
  assign bus.flush_cnt   = fcnt_q;
endmodule
